// File: rtl/segment_pkg.sv
// Shared constants for the seven-segment display driver: segment width,
// blank pattern, decimal-point off level and the active-low gfedcba glyph table.
package segment_pkg;

  localparam int SEG_W = 7;

  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  localparam logic SEG_DP_OFF = 1'b1;

  // Active-low gfedcba patterns for hex digits 0..F
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/seg_decode.sv
// Combinational nibble-to-segment decoder with a blank override.
module seg_decode
  import segment_pkg::*;
(
  input  logic [3:0]       nibble,
  input  logic             blank,
  output logic [SEG_W-1:0] seg
);

  // Blank wins over the glyph lookup
  always_comb begin
    seg = blank ? SEG_BLANK : SEG_TABLE[nibble];
  end

endmodule

// File: rtl/segment_ctrl.sv
// Registered driver for a bank of active-low seven-segment HEX displays.
// Latches a packed hex value, adds per-digit blink, leading-zero suppression
// and a global enable. Optional decimal points: define SEGMENT_DP_EN to add
// the dp input and widen each digit of dst to 8 bits (bit 7 = point).
module segment_ctrl
  import segment_pkg::*;
#(
  parameter int DIGITS    = 6,
  parameter int BLINK_DIV = 25_000_000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load,
  input  logic                  clear,
  input  logic [4*DIGITS-1:0]   data,
  input  logic                  en,
  input  logic                  blank_lz,
  input  logic [DIGITS-1:0]     blink_mask,
`ifdef SEGMENT_DP_EN
  input  logic [DIGITS-1:0]     dp,
  output logic [8*DIGITS-1:0]   dst
`else
  output logic [7*DIGITS-1:0]   dst
`endif
);

  localparam int CNT_W = $clog2(BLINK_DIV);

`ifdef SEGMENT_DP_EN
  localparam int               DIG_W   = SEG_W + 1;
  localparam logic [DIG_W-1:0] DIG_RST = {SEG_DP_OFF, SEG_BLANK};
`else
  localparam int               DIG_W   = SEG_W;
  localparam logic [DIG_W-1:0] DIG_RST = SEG_BLANK;
`endif

  logic [4*DIGITS-1:0]     val;
  logic [CNT_W-1:0]        cnt;
  logic                    phase;
  logic [DIGITS-1:0]       zero_up;
  logic [DIGITS-1:0]       lz_blank;
  logic [DIGITS-1:0]       vis_blank;
  logic [DIG_W*DIGITS-1:0] dst_next;

  // Value register: load takes priority over clear
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      val <= '0;
    end else if (load) begin
      val <= data;
    end else if (clear) begin
      val <= '0;
    end
  end

  // Blink timer: phase flips every BLINK_DIV cycles, starts visible
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      phase <= 1'b1;
    end else if (cnt == CNT_W'(BLINK_DIV - 1)) begin
      cnt   <= '0;
      phase <= ~phase;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < DIGITS; g++) begin : g_digit
    logic [SEG_W-1:0] seg;

    // zero_up[g] is set when nibbles g..DIGITS-1 are all zero
    if (g == DIGITS - 1) begin : g_top
      assign zero_up[g] = (val[4*g +: 4] == 4'd0);
    end else begin : g_chain
      assign zero_up[g] = (val[4*g +: 4] == 4'd0) & zero_up[g+1];
    end

    // The least significant digit always shows, even when zero
    if (g == 0) begin : g_lsd
      assign lz_blank[g] = 1'b0;
    end else begin : g_upper
      assign lz_blank[g] = blank_lz & zero_up[g];
    end

    assign vis_blank[g] = ~en | (blink_mask[g] & ~phase);

    seg_decode u_dec (
      .nibble (val[4*g +: 4]),
      .blank  (vis_blank[g] | lz_blank[g]),
      .seg    (seg)
    );

`ifdef SEGMENT_DP_EN
    assign dst_next[DIG_W*g +: DIG_W] =
      {((dp[g] & ~vis_blank[g] & ~lz_blank[g]) ? ~SEG_DP_OFF : SEG_DP_OFF), seg};
`else
    assign dst_next[DIG_W*g +: DIG_W] = seg;
`endif
  end

  // Output register: pins change one edge after val/phase/controls
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dst <= {DIGITS{DIG_RST}};
    end else begin
      dst <= dst_next;
    end
  end

endmodule
